cache_fill_sequencer: RTL and testbench
=======================================

Name: cache_fill_sequencer

Overview:
- Sits directly downstream of the two-way cache, between the cache's SDRAM miss port and the SDRAM controller's burst read port.
- On a read miss it issues one aligned 4-word burst read to the controller and collects the words into a 4x16 buffer. The controller may insert gaps between words.
- It then replays the words to the cache critical-word-first, on 4 consecutive cycles. The first replay cycle is flagged by cache_fill, which is the gap-free timing the cache's FILL states require.

Parameters:
- ADDR_W, 26, width of mem_addr in bytes; covers a 64 MB space.
- TIMEOUT, 255, cycle limit for the watchdog; used only with CACHEFILL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cache_req  in  1  miss request; held high by the cache until it sees cache_fill.
- cache_rw  in  1  1=read; requests with 0 are ignored.
- cache_addr  in  32  line address from the cache; bits [2:0] are ignored.
- cache_word  in  2  critical word index, taken from CPU address [2:1]; sampled with cache_req.
- cache_fill  out  1  one-cycle pulse that marks the first replayed word.
- cache_data  out  16  replay data.
- mem_req  out  1  burst read request to the controller.
- mem_addr  out  ADDR_W  {cache_addr[ADDR_W-1:3],3'b000}.
- mem_ack  in  1  controller has accepted the request.
- mem_valid  in  1  one data word is valid on mem_data.
- mem_data  in  16  burst data, returned in linear order 0..3.
- busy  out  1  high in any state other than IDLE.
- fill_err  out  1  sticky timeout flag.

Behaviour:
- Reset values: state=IDLE; cache_fill, mem_req, busy, fill_err = 0; cache_data, mem_addr = 0. Buffer contents are don't-care.
- IDLE:
  - If cache_req=1 and cache_rw=1: latch mem_addr and crit=cache_word, clear wcnt, set mem_req=1, go to REQ.
  - mem_valid is ignored in IDLE.
- REQ:
  - Hold mem_req until mem_ack=1, then clear mem_req and go to COLLECT.
  - If mem_valid=1 in the same cycle as mem_ack, that word is stored as word 0.
- COLLECT:
  - Each mem_valid stores mem_data into buf[wcnt] and increments wcnt (2-bit).
  - On the 4th stored word go to REPLAY; there is no dead cycle.
  - mem_valid after the 4th word is ignored.
- REPLAY, 4 cycles, idx = crit + k mod 4 (2-bit wrap), k = 0..3:
  - k=0: cache_fill=1, cache_data=buf[crit].
  - k=1..3: cache_fill=0, cache_data=buf[crit+k].
  - After k=3 go to DRAIN.
  - Example: crit=2 gives the order 2,3,0,1.
- DRAIN: wait for cache_req=0, then go to IDLE.
  - The cache drops its request on the fill cycle, so DRAIN normally lasts 1 cycle.
  - A new request is never accepted before IDLE.
- Outputs are registered.
- cache_data holds its last value outside REPLAY. cache_fill is 0 outside REPLAY k=0.
- Latency: from cache_req sampled to mem_req high is 1 cycle. From 4th mem_valid to cache_fill high is 1 cycle.
- cache_req dropping during REQ or COLLECT: the burst still completes and replays. The cache ignores data it did not request.
- Reset mid-operation: return to IDLE in 1 cycle with mem_req=0 and the buffer abandoned. The controller is reset by the same signal.
- Write requests (cache_rw=0) produce no mem_req and no response.

Optional Feature:
- Macro: CACHEFILL_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and COLLECT and clears on entry to REQ.
  - When it reaches TIMEOUT: drop mem_req, set fill_err=1 (sticky until reset), and fill every unreceived buffer slot with 16'hFFFF.
  - Then go to REPLAY and replay normally, so the cache never hangs.
- Not defined: no counter; the block waits indefinitely; fill_err is tied to 0.

Test Plan:
- Linear replay: cache_addr=0x0001_2340, word=0; ack on cycle 2; data 0xA0,0xA1,0xA2,0xA3 back-to-back -> mem_addr=0x0012340; replay A0(fill=1),A1,A2,A3 on consecutive cycles.
- Wrap replay: word=3; data 0xB0..0xB3 with 2-cycle gaps -> replay B3(fill=1),B0,B1,B2 with no gaps.
- Same-cycle ack and valid: mem_ack and mem_valid high together carrying 0xC0 -> 0xC0 stored as word 0; replay correct.
- Write ignored: cache_req=1, cache_rw=0 for 10 cycles -> mem_req stays 0, busy stays 0.
- Reset mid-burst: reset after 2 words, then a new request -> mem_req=0 the cycle after reset; the new burst replays only the new data.
- Timeout (macro on, TIMEOUT=8): ack followed by one word 0xD0, then silence -> fill_err=1; replay D0,FFFF,FFFF,FFFF.

Source files
------------

// File: rtl/cache_fill_if.sv
// Bus between the two-way cache miss port, the fill sequencer and the SDRAM burst read port.
// The "slave" modport is the sequencer; "master" is whatever drives the cache and controller sides.
interface cache_fill_if #(
  parameter int ADDR_W = 26
);
  logic              cache_req;
  logic              cache_rw;
  logic [31:0]       cache_addr;
  logic [1:0]        cache_word;
  logic              cache_fill;
  logic [15:0]       cache_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_valid;
  logic [15:0]       mem_data;

  modport master (
    output cache_req, cache_rw, cache_addr, cache_word, mem_ack, mem_valid, mem_data,
    input  cache_fill, cache_data, mem_req, mem_addr
  );

  modport slave (
    input  cache_req, cache_rw, cache_addr, cache_word, mem_ack, mem_valid, mem_data,
    output cache_fill, cache_data, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_fill_sequencer.sv
// Fetches an aligned 4-word SDRAM burst on a cache read miss and replays it critical-word-first.
// Optional watchdog: define CACHEFILL_TIMEOUT_EN to bound the wait for the controller.
module cache_fill_sequencer #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  cache_fill_if.slave bus,
  output logic       busy,
  output logic       fill_err,
  output logic [2:0] dbg_state
);
  // Handshake: mem_req rises with the accepted miss and stays high until the cycle
  // mem_ack is seen; each mem_valid cycle carries exactly one word, in order 0..3.
  typedef enum logic [2:0] {IDLE, REQ, COLLECT, REPLAY, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        crit_q, crit_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [1:0]        k_q, k_d;
  logic [15:0]       buf_q [4];
  logic [15:0]       buf_d [4];
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              cache_fill_q, cache_fill_d;
  logic [15:0]       cache_data_q, cache_data_d;
  logic              busy_q, busy_d;
  logic              go_replay;
  logic [1:0]        ridx;

`ifdef CACHEFILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          fill_err_q, fill_err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cache_addr[31:ADDR_W], bus.cache_addr[2:0]};

  always_comb begin
    state_d      = state_q;
    crit_d       = crit_q;
    wcnt_d       = wcnt_q;
    k_d          = k_q;
    buf_d        = buf_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    cache_fill_d = 1'b0;
    cache_data_d = cache_data_q;
    go_replay    = 1'b0;
    ridx         = crit_q + k_q;
`ifdef CACHEFILL_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    fill_err_d   = fill_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cache_req && bus.cache_rw) begin
          mem_addr_d = {bus.cache_addr[ADDR_W-1:3], 3'b000};
          crit_d     = bus.cache_word;
          wcnt_d     = 2'd0;
          mem_req_d  = 1'b1;
          state_d    = REQ;
`ifdef CACHEFILL_TIMEOUT_EN
          tcnt_d     = '0;
`endif
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = COLLECT;
          if (bus.mem_valid) begin
            buf_d[0] = bus.mem_data;
            wcnt_d   = 2'd1;
          end
        end
      end
      COLLECT: begin
        if (bus.mem_valid) begin
          buf_d[wcnt_q] = bus.mem_data;
          wcnt_d        = wcnt_q + 2'd1;
          go_replay     = (wcnt_q == 2'd3);
        end
      end
      REPLAY: begin
        cache_data_d = buf_q[ridx];
        k_d          = k_q + 2'd1;
        if (k_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.cache_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef CACHEFILL_TIMEOUT_EN
    if (state_q == REQ || state_q == COLLECT) begin
      tcnt_d = tcnt_q + 1'b1;
      // A burst that completes on the same cycle the watchdog expires is kept.
      if (tcnt_q == TW'(TIMEOUT) && !go_replay) begin
        mem_req_d  = 1'b0;
        fill_err_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (2'(i) >= wcnt_q) buf_d[i] = 16'hFFFF;
        end
        go_replay = 1'b1;
      end
    end
`endif

    // The first replayed word leaves on the same edge the last word lands.
    if (go_replay) begin
      state_d      = REPLAY;
      cache_fill_d = 1'b1;
      cache_data_d = buf_d[crit_q];
      k_d          = 2'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      crit_q       <= 2'd0;
      wcnt_q       <= 2'd0;
      k_q          <= 2'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cache_fill_q <= 1'b0;
      cache_data_q <= 16'd0;
      busy_q       <= 1'b0;
`ifdef CACHEFILL_TIMEOUT_EN
      tcnt_q       <= '0;
      fill_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      crit_q       <= crit_d;
      wcnt_q       <= wcnt_d;
      k_q          <= k_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cache_fill_q <= cache_fill_d;
      cache_data_q <= cache_data_d;
      busy_q       <= busy_d;
`ifdef CACHEFILL_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      fill_err_q   <= fill_err_d;
`endif
    end
  end

  // Buffer contents are meaningless until a burst has landed, so they are not reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.cache_fill = cache_fill_q;
  assign bus.cache_data = cache_data_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;
`ifdef CACHEFILL_TIMEOUT_EN
  assign fill_err       = fill_err_q;
`else
  assign fill_err       = 1'b0;
`endif
endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Directed bench for cache_fill_sequencer: linear/wrapped replay, gaps, same-cycle ack+data,
// writes, mid-burst reset and (with CACHEFILL_TIMEOUT_EN) the watchdog path.
module tb_cache_fill_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       fill_err;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  cache_fill_if #(.ADDR_W(26)) bus ();

  cache_fill_sequencer #(.ADDR_W(26), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .fill_err  (fill_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // d and e are packed with element 0 in the low bits; e[k] is the k-th replayed word.
  task automatic do_fill(input logic [31:0] addr, input logic [1:0] word,
                         input logic [3:0][15:0] d, input int gap, input bit ack_with_data,
                         input bit drop_early, input logic [25:0] exp_addr,
                         input logic [3:0][15:0] e);
    int first;
    bus.cache_req = 1'b1; bus.cache_rw = 1'b1; bus.cache_addr = addr; bus.cache_word = word;
    tick();
    chk("req_rise", 32'(bus.mem_req), 32'd1);
    chk("req_addr", 32'(bus.mem_addr), 32'(exp_addr));
    chk("busy_req", 32'(busy), 32'd1);
    tick();
    chk("req_hold", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    first = 0;
    if (ack_with_data) begin
      bus.mem_valid = 1'b1; bus.mem_data = d[0];
      first = 1;
    end
    tick();
    bus.mem_ack = 1'b0; bus.mem_valid = 1'b0;
    chk("req_drop", 32'(bus.mem_req), 32'd0);
    if (drop_early) bus.cache_req = 1'b0;
    for (int i = first; i < 4; i++) begin
      if (i > 0) repeat (gap) begin
        tick();
        chk("no_early_fill", 32'(bus.cache_fill), 32'd0);
      end
      bus.mem_valid = 1'b1; bus.mem_data = d[i];
      tick();
      bus.mem_valid = 1'b0;
    end
    chk("fill_k0", 32'(bus.cache_fill), 32'd1);
    chk("data_k0", 32'(bus.cache_data), 32'(e[0]));
    bus.cache_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("fill_kn", 32'(bus.cache_fill), 32'd0);
      chk("data_kn", 32'(bus.cache_data), 32'(e[k]));
    end
    chk("busy_drain", 32'(busy), 32'd1);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("state_idle", 32'(dbg_state), 32'd0);
    chk("data_hold", 32'(bus.cache_data), 32'(e[3]));
  endtask

  initial begin
    reset = 1'b1;
    bus.cache_req = 1'b0; bus.cache_rw = 1'b0; bus.cache_addr = 32'd0; bus.cache_word = 2'd0;
    bus.mem_ack = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = 16'd0;
    tick();
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill", 32'(bus.cache_fill), 32'd0);
    chk("rst_data", 32'(bus.cache_data), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_err", 32'(fill_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Stray data while idle must not start anything.
    bus.mem_valid = 1'b1; bus.mem_data = 16'h9999;
    tick();
    bus.mem_valid = 1'b0;
    chk("idle_valid_busy", 32'(busy), 32'd0);

    // Linear: word 0, back-to-back data.
    do_fill(32'h0001_2340, 2'd0, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 0, 1'b0, 1'b0,
            26'h0012340, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    chk("err_clear", 32'(fill_err), 32'd0);

    // Wrap: word 3 with 2-cycle gaps; upper and low address bits dropped.
    do_fill(32'h0ABC_DEF7, 2'd3, {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0}, 2, 1'b0, 1'b0,
            26'h2BCDEF0, {16'h00B2, 16'h00B1, 16'h00B0, 16'h00B3});

    // Ack and first word on the same cycle.
    do_fill(32'h0000_1008, 2'd1, {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0}, 1, 1'b1, 1'b0,
            26'h0001008, {16'h00C0, 16'h00C3, 16'h00C2, 16'h00C1});

    // Cache abandons the request mid-burst; replay still happens.
    do_fill(32'h0000_0010, 2'd2, {16'h5553, 16'h5552, 16'h5551, 16'h5550}, 0, 1'b0, 1'b1,
            26'h0000010, {16'h5551, 16'h5550, 16'h5553, 16'h5552});

    // Writes are ignored.
    bus.cache_req = 1'b1; bus.cache_rw = 1'b0; bus.cache_addr = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wr_mem_req", 32'(bus.mem_req), 32'd0);
      chk("wr_busy", 32'(busy), 32'd0);
    end
    bus.cache_req = 1'b0;

    // Reset while mem_req is pending.
    bus.cache_req = 1'b1; bus.cache_rw = 1'b1; bus.cache_addr = 32'h0000_0300;
    bus.cache_word = 2'd0;
    tick();
    chk("rreq_up", 32'(bus.mem_req), 32'd1);
    bus.cache_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rreq_down", 32'(bus.mem_req), 32'd0);
    chk("rreq_state", 32'(dbg_state), 32'd0);

    // Reset after two words of a burst, then a fresh burst.
    bus.cache_req = 1'b1; bus.cache_rw = 1'b1; bus.cache_addr = 32'h0000_0400;
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_data = 16'h00E0;
    tick();
    bus.mem_data = 16'h00E1;
    tick();
    bus.mem_valid = 1'b0; bus.cache_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_fill", 32'(bus.cache_fill), 32'd0);
    do_fill(32'h0000_0408, 2'd1, {16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0}, 0, 1'b0, 1'b0,
            26'h0000408, {16'h00F0, 16'h00F3, 16'h00F2, 16'h00F1});

`ifdef CACHEFILL_TIMEOUT_EN
    // Watchdog: one word then silence.
    begin
      int n;
      bus.cache_req = 1'b1; bus.cache_rw = 1'b1; bus.cache_addr = 32'h0000_0500;
      bus.cache_word = 2'd0;
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_data = 16'h00D0;
      tick();
      bus.mem_valid = 1'b0;
      n = 0;
      while (!bus.cache_fill && n < 40) begin
        tick();
        n++;
      end
      chk("to_fill", 32'(bus.cache_fill), 32'd1);
      chk("to_err", 32'(fill_err), 32'd1);
      chk("to_d0", 32'(bus.cache_data), 32'h0000_00D0);
      chk("to_mem_req", 32'(bus.mem_req), 32'd0);
      bus.cache_req = 1'b0;
      for (int k = 1; k < 4; k++) begin
        tick();
        chk("to_pad", 32'(bus.cache_data), 32'h0000_FFFF);
      end
      tick();
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_sticky", 32'(fill_err), 32'd1);
    end
`else
    chk("err_tied", 32'(fill_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
